// File: rtl/calc_core_bcd.sv
`timescale 1ns/1ps
// calc_core_bcd
// Multi-digit integer calculator engine between the keypad one-shot stage and
// the character-LCD driver. Two operands of up to DIGITS decimal digits are
// entered as key pulses, combined by add/sub/mul in binary, and the binary
// result is converted to BCD with a sequential double-dabble pass.
//
// Ports:
//   clk_100hz  system clock
//   rst        asynchronous active-high reset
//   key_valid  single-cycle key strobe
//   key_code   0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 clear, 15 ignored
//   a_bcd      operand A, BCD, right-aligned
//   b_bcd      operand B, BCD, right-aligned
//   op         00 none, 01 add, 10 sub, 11 mul
//   res_bcd    result magnitude, BCD (2*DIGITS digits)
//   res_neg    result sign
//   busy       high while calculating or converting
//   done       one-cycle pulse when res_bcd becomes valid
//   err        sticky flag: chaining attempted with a result that cannot be A
//   state_o    current state encoding
module calc_core_bcd #(
  parameter int DIGITS = 2,
  parameter int OPW    = 7
) (
  input  logic                  clk_100hz,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   a_bcd,
  output logic [4*DIGITS-1:0]   b_bcd,
  output logic [1:0]            op,
  output logic [8*DIGITS-1:0]   res_bcd,
  output logic                  res_neg,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_o
);

  localparam int RW  = 2 * OPW;
  localparam int RD  = 2 * DIGITS;
  localparam int DW  = 4 * RD + RW;        // double-dabble working register
  localparam int CW  = $clog2(RW + 1);     // covers both OPW and RW cycle counts
  localparam int DCW = $clog2(DIGITS + 1);

  function automatic logic [RW-1:0] pow10(input int n);
    logic [RW-1:0] p;
    p = RW'(1);
    for (int i = 0; i < n; i++) p = p * RW'(10);
    return p;
  endfunction

  // Smallest value that no longer fits in a DIGITS-digit operand.
  localparam logic [RW-1:0] LIMIT = pow10(DIGITS);

  typedef enum logic [2:0] {
    ENTER_A = 3'b000,
    ENTER_B = 3'b001,
    CALC    = 3'b010,
    CONV    = 3'b011,
    SHOW    = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic [OPW-1:0]      a_bin_q, a_bin_d, b_bin_q, b_bin_d;
  logic [4*DIGITS-1:0] a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
  logic [DCW-1:0]      a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [1:0]          op_q, op_d;
  logic [RW-1:0]       r_q, r_d;
  logic [RW-1:0]       mcand_q, mcand_d;
  logic [OPW-1:0]      mplier_q, mplier_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dd_q, dd_d;
  logic [4*RD-1:0]     res_bcd_q, res_bcd_d;
  logic                res_neg_q, res_neg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Key decode
  logic       is_digit, is_op, is_eq, is_clr;
  logic [1:0] key_op;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_eq    = key_valid && (key_code == 4'd13);
  assign is_clr   = key_valid && (key_code == 4'd14);

  always_comb begin
    key_op = 2'b00;
    case (key_code)
      4'd10:   key_op = 2'b01;
      4'd11:   key_op = 2'b10;
      4'd12:   key_op = 2'b11;
      default: key_op = 2'b00;
    endcase
  end

  // One shift-add multiply step: accumulate the shifted multiplicand when the
  // current multiplier LSB is set.
  logic [RW-1:0] prod_step;
  assign prod_step = r_q + (mplier_q[0] ? mcand_q : '0);

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole
  // {bcd, binary} register left by one.
  logic [4*RD-1:0] dd_adj;
  logic [DW-1:0]   dd_shift;

  for (genvar gi = 0; gi < RD; gi++) begin : g_dabble
    logic [3:0] nib;
    assign nib                  = dd_q[RW + 4*gi +: 4];
    assign dd_adj[4*gi +: 4]    = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  assign dd_shift = {dd_adj, dd_q[RW-1:0]} << 1;

  always_comb begin
    state_d   = state_q;
    a_bin_d   = a_bin_q;
    b_bin_d   = b_bin_q;
    a_bcd_d   = a_bcd_q;
    b_bcd_d   = b_bcd_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    op_d      = op_q;
    r_d       = r_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    dd_d      = dd_q;
    res_bcd_d = res_bcd_q;
    res_neg_d = res_neg_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ENTER_A: begin
        if (is_digit) begin
          if (a_cnt_q < DCW'(DIGITS)) begin
            a_bin_d = a_bin_q * OPW'(10) + OPW'(key_code);
            a_bcd_d = (a_bcd_q << 4) | (4*DIGITS)'(key_code);
            a_cnt_d = a_cnt_q + 1'b1;
          end
        end else if (is_op) begin
          op_d    = key_op;
          state_d = ENTER_B;
        end
      end

      ENTER_B: begin
        if (is_digit) begin
          if (b_cnt_q < DCW'(DIGITS)) begin
            b_bin_d = b_bin_q * OPW'(10) + OPW'(key_code);
            b_bcd_d = (b_bcd_q << 4) | (4*DIGITS)'(key_code);
            b_cnt_d = b_cnt_q + 1'b1;
          end
        end else if (is_op) begin
          op_d = key_op;
        end else if (is_eq) begin
          // Multiplier setup is done here for every op; add/sub ignore it.
          // An empty B is already binary zero.
          r_d      = '0;
          mcand_d  = RW'(a_bin_q);
          mplier_d = b_bin_q;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (op_q == 2'b11) begin
          res_neg_d = 1'b0;
          r_d       = prod_step;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          if (cnt_q == CW'(OPW - 1)) begin
            dd_d    = DW'(prod_step);
            cnt_d   = '0;
            state_d = CONV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (op_q == 2'b10) begin
            // Magnitude plus sign, so subtraction never wraps.
            if (a_bin_q >= b_bin_q) begin
              r_d       = RW'(a_bin_q - b_bin_q);
              res_neg_d = 1'b0;
            end else begin
              r_d       = RW'(b_bin_q - a_bin_q);
              res_neg_d = 1'b1;
            end
          end else begin
            r_d       = RW'(a_bin_q) + RW'(b_bin_q);
            res_neg_d = 1'b0;
          end
          dd_d    = DW'(r_d);
          cnt_d   = '0;
          state_d = CONV;
        end
      end

      CONV: begin
        dd_d = dd_shift;
        if (cnt_q == CW'(RW - 1)) begin
          // Final shift lands directly in the result register.
          res_bcd_d = dd_shift[DW-1 -: 4*RD];
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHOW: begin
        if (is_digit) begin
          a_bin_d = OPW'(key_code);
          a_bcd_d = (4*DIGITS)'(key_code);
          a_cnt_d = DCW'(1);
          b_bin_d = '0;
          b_bcd_d = '0;
          b_cnt_d = '0;
          op_d    = 2'b00;
          err_d   = 1'b0;
          state_d = ENTER_A;
        end else if (is_op) begin
          if (!res_neg_q && (r_q < LIMIT)) begin
            a_bin_d = r_q[OPW-1:0];
            a_bcd_d = res_bcd_q[4*DIGITS-1:0];
            a_cnt_d = DCW'(DIGITS);
            b_bin_d = '0;
            b_bcd_d = '0;
            b_cnt_d = '0;
            op_d    = key_op;
            state_d = ENTER_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ENTER_A;
    endcase

    // Clear wins over everything, including an operation in flight.
    if (is_clr) begin
      state_d   = ENTER_A;
      a_bin_d   = '0;
      b_bin_d   = '0;
      a_bcd_d   = '0;
      b_bcd_d   = '0;
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      op_d      = 2'b00;
      r_d       = '0;
      mcand_d   = '0;
      mplier_d  = '0;
      cnt_d     = '0;
      dd_d      = '0;
      res_bcd_d = '0;
      res_neg_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end

    busy_d = (state_d == CALC) || (state_d == CONV);
  end

  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      state_q   <= ENTER_A;
      a_bin_q   <= '0;
      b_bin_q   <= '0;
      a_bcd_q   <= '0;
      b_bcd_q   <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      op_q      <= 2'b00;
      r_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      dd_q      <= '0;
      res_bcd_q <= '0;
      res_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_bin_q   <= a_bin_d;
      b_bin_q   <= b_bin_d;
      a_bcd_q   <= a_bcd_d;
      b_bcd_q   <= b_bcd_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      op_q      <= op_d;
      r_q       <= r_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      dd_q      <= dd_d;
      res_bcd_q <= res_bcd_d;
      res_neg_q <= res_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign a_bcd   = a_bcd_q;
  assign b_bcd   = b_bcd_q;
  assign op      = op_q;
  assign res_bcd = res_bcd_q;
  assign res_neg = res_neg_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: doc/calc_core_bcd.md
Name: calc_core_bcd

Overview:
- Parametrised multi-digit integer calculator engine. Sits between the keypad one-shot logic and the character-LCD driver.
- Accepts digit and operator key pulses and accumulates two operands of up to DIGITS decimal digits each. Supports add, subtract and multiply.
- Computes in binary, then converts the result to BCD sequentially (double dabble). The LCD driver renders the BCD and flag outputs directly.

Parameters:
- DIGITS, 2, maximum decimal digits per operand.
- OPW, 7, binary operand width; must satisfy 2^OPW >= 10^DIGITS.
- Derived, not overridable: RW = 2*OPW (result binary width); RD = 2*DIGITS (result BCD digits).

Ports:
- clk_100hz  in  1  system clock.
- rst  in  1  reset.
- key_valid  in  1  single-cycle key pulse from the one-shot stage.
- key_code  in  4  0-9 digit; 10 '+'; 11 '-'; 12 '*'; 13 '='; 14 clear; 15 reserved (ignored).
- a_bcd  out  4*DIGITS  operand A, BCD, right-aligned.
- b_bcd  out  4*DIGITS  operand B, BCD, right-aligned.
- op  out  2  00 none, 01 add, 10 sub, 11 mul.
- res_bcd  out  4*RD  result magnitude, BCD.
- res_neg  out  1  result sign.
- busy  out  1  high in CALC and CONV.
- done  out  1  one-cycle pulse when the result becomes valid.
- err  out  1  sticky chaining-overflow flag.
- state_o  out  3  current state encoding.

Behaviour:
- Reset is asynchronous, active-high (rst); the block is clocked on clk_100hz.
- On reset: all outputs 0, internal binary regs 0, digit counters 0, state = ENTER_A (encoding 000).
- States:
  - ENTER_A (000), ENTER_B (001), CALC (010), CONV (011), SHOW (100).
  - Keys are sampled only on edges where key_valid = 1.
- ENTER_A:
  - Digit: if a_cnt < DIGITS, then a_bin <= a_bin*10 + d, a_bcd <= {a_bcd << 4, d}, a_cnt++. Otherwise the digit is ignored.
  - Operator: op set, go to ENTER_B.
  - '=' is ignored.
- ENTER_B:
  - Digits are handled as in ENTER_A, into b_bin, b_bcd, b_cnt.
  - A new operator overwrites op and stays in ENTER_B.
  - '=' goes to CALC. If b_cnt = 0, B = 0 is used.
- CALC:
  - add: r <= a+b, 1 cycle.
  - sub: if a >= b then r <= a-b, res_neg <= 0; else r <= b-a, res_neg <= 1. 1 cycle.
  - mul: shift-add, exactly OPW cycles.
  - Then go to CONV.
- CONV:
  - Double dabble over r, exactly RW cycles: add 3 to any nibble >= 5, then shift left 1.
  - Then res_bcd is loaded and the block goes to SHOW with done = 1 for that one cycle.
- Latency from the edge sampling '=' to done high: add/sub 1+RW cycles (15 at defaults); mul OPW+RW cycles (21 at defaults).
- SHOW:
  - Digit: clear A, B, op and err, load the digit as the first digit of A, go to ENTER_A.
  - Operator (chaining): if res_neg = 0 and result < 10^DIGITS, load A from the result (binary and low DIGITS BCD digits, a_cnt = DIGITS), clear B, set op, go to ENTER_B. Otherwise set err = 1, stay in SHOW.
  - '=' is ignored.
- Clear (key 14):
  - Honoured in every state, including CALC and CONV (aborts the operation).
  - All registers return to reset values, state ENTER_A, next cycle.
- Busy handling: keys other than clear during CALC or CONV are dropped, not queued.
- Width rules:
  - Subtraction never wraps: the magnitude is held in r and the sign in res_neg.
  - A mul result is at most (10^DIGITS - 1)^2, which fits RW bits and RD BCD digits.
- Outputs are registered. done never asserts while busy = 1.

Test Plan:
- Keys 7,+,5,= -> done exactly 15 cycles after '='; res_bcd = 0x0012, res_neg = 0, op = 01.
- Keys 3,-,8,= -> res_bcd = 0x0005, res_neg = 1; then 8,-,3,= -> 0x0005, res_neg = 0.
- Keys 9,9,*,9,9,= -> busy high 21 cycles, done at cycle 21, res_bcd = 0x9801; a_bcd = b_bcd = 0x99.
- Keys 1,2,3 in ENTER_A -> a_bcd = 0x12, a_cnt stays 2, third digit ignored; key 15 -> no change.
- 1,2,+,3,= then +,4,= -> chained A = 0x15, final res_bcd = 0x0019. Then 6,0,*,2,= then + -> err = 1, state stays SHOW; next digit clears err.
- Clear at cycle 5 of CONV -> all outputs 0, state ENTER_A, no done pulse. rst asserted mid-multiply -> immediate reset values; system resumes accepting keys after release.
